// File: rtl/preg_freelist_pkg.sv
// ----------------------------------------------------------------------------
// Package C: machine-wide physical register file sizing shared by rename,
// the free list and the register file itself.
//   PRFSIZE      : number of physical registers (power of two, >= 2)
//   PREG_ID_BITS : width of a physical register id, log2(PRFSIZE)
//   preg_id_t    : physical register id type used across the back end
// ----------------------------------------------------------------------------
package C;

    localparam int PRFSIZE      = 8;
    localparam int PREG_ID_BITS = $clog2(PRFSIZE);

    typedef logic [PREG_ID_BITS-1:0] preg_id_t;

endpackage : C

// File: rtl/preg_freelist.sv
// ----------------------------------------------------------------------------
// preg_freelist
//   Physical register free list. Free ids live in an NPREG-entry circular
//   FIFO (read at head by rename, written at tail by commit). A per-preg
//   allocated bitvector detects double/spurious frees, which raise a sticky
//   error flag instead of corrupting the list.
//
// Ports
//   clk           : clock, all state updates on the rising edge
//   rstn          : asynchronous active-low reset
//   alloc_i       : rename consumes one preg this cycle
//   alloc_ready_o : at least one preg is free
//   alloc_preg_o  : preg handed out on a grant (valid while alloc_ready_o=1)
//   free_i        : commit releases one preg this cycle
//   free_preg_i   : preg being released
//   count_o       : number of free pregs (0..NPREG)
//   err_o         : sticky protocol error (illegal free seen)
// ----------------------------------------------------------------------------
module preg_freelist
    import C::*;
#(
    parameter int NPREG = C::PRFSIZE,
    parameter int IDW   = C::PREG_ID_BITS
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           alloc_i,
    output logic           alloc_ready_o,
    output logic [IDW-1:0] alloc_preg_o,
    input  logic           free_i,
    input  logic [IDW-1:0] free_preg_i,
    output logic [IDW:0]   count_o,
    output logic           err_o
);

    localparam logic [IDW-1:0] ID_ONE    = IDW'(1);
    localparam logic [IDW:0]   CNT_ONE   = (IDW + 1)'(1);
    localparam logic [IDW:0]   CNT_ZERO  = (IDW + 1)'(0);
    localparam logic [IDW:0]   CNT_FULL  = (IDW + 1)'(NPREG);
    localparam logic [IDW-1:0] PTR_ZERO  = IDW'(0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDW-1:0]   fifo_r [NPREG];
    logic [IDW-1:0]   head_r;
    logic [IDW-1:0]   tail_r;
    logic [IDW:0]     count_r;
    logic [NPREG-1:0] alloc_vec_r;
    logic             err_r;

    logic [IDW-1:0]   head_nxt_s;
    logic [IDW-1:0]   tail_nxt_s;
    logic [IDW:0]     count_nxt_s;
    logic [NPREG-1:0] alloc_vec_nxt_s;
    logic             err_nxt_s;

    logic             ready_s;
    logic [IDW-1:0]   head_id_s;
    logic             grant_s;
    logic             free_ok_s;
    logic             free_bad_s;

    // Allocation port is a pure function of registered state, so rename sees
    // no combinational path from its own alloc_i or from commit's free_i.
    assign ready_s   = (count_r != CNT_ZERO);
    assign head_id_s = fifo_r[head_r];

    assign alloc_ready_o = ready_s;
    assign alloc_preg_o  = head_id_s;
    assign count_o       = count_r;
    assign err_o         = err_r;

    // Legality of a free is judged on pre-update state. An id sitting in the
    // FIFO has its allocated bit clear, so freeing the id being granted in the
    // same cycle is flagged illegal and the grant still marks it allocated.
    assign grant_s    = alloc_i & ready_s;
    assign free_ok_s  = free_i & alloc_vec_r[free_preg_i];
    assign free_bad_s = free_i & ~alloc_vec_r[free_preg_i];

    // Next-state for pointers, count, allocated bitvector and error flag.
    always_comb begin
        head_nxt_s      = head_r;
        tail_nxt_s      = tail_r;
        count_nxt_s     = count_r;
        alloc_vec_nxt_s = alloc_vec_r;
        err_nxt_s       = err_r;

        if (grant_s) begin
            head_nxt_s = head_r + ID_ONE;
        end else begin
            head_nxt_s = head_r;
        end

        if (free_ok_s) begin
            tail_nxt_s = tail_r + ID_ONE;
        end else begin
            tail_nxt_s = tail_r;
        end

        // Simultaneous grant and legal free cancel out on the count.
        case ({grant_s, free_ok_s})
            2'b10:   count_nxt_s = count_r - CNT_ONE;
            2'b01:   count_nxt_s = count_r + CNT_ONE;
            2'b11:   count_nxt_s = count_r;
            default: count_nxt_s = count_r;
        endcase

        // Clear before set: a legal free can never target the granted id,
        // but ordering it this way keeps a granted id allocated regardless.
        if (free_ok_s) begin
            alloc_vec_nxt_s[free_preg_i] = 1'b0;
        end else begin
            alloc_vec_nxt_s = alloc_vec_nxt_s;
        end

        if (grant_s) begin
            alloc_vec_nxt_s[head_id_s] = 1'b1;
        end else begin
            alloc_vec_nxt_s = alloc_vec_nxt_s;
        end

        if (free_bad_s) begin
            err_nxt_s = 1'b1;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Control state registers; reset returns every preg to the free list.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_r      <= PTR_ZERO;
            tail_r      <= PTR_ZERO;
            count_r     <= CNT_FULL;
            alloc_vec_r <= {NPREG{1'b0}};
            err_r       <= 1'b0;
        end else begin
            head_r      <= head_nxt_s;
            tail_r      <= tail_nxt_s;
            count_r     <= count_nxt_s;
            alloc_vec_r <= alloc_vec_nxt_s;
            err_r       <= err_nxt_s;
        end
    end

    // FIFO storage: single write port at tail, reset to the identity list.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NPREG; i++) begin
                fifo_r[i] <= IDW'(i);
            end
        end else if (free_ok_s) begin
            fifo_r[tail_r] <= free_preg_i;
        end else begin
            fifo_r[tail_r] <= fifo_r[tail_r];
        end
    end

endmodule : preg_freelist

// File: tb/tb_preg_freelist.sv
// ----------------------------------------------------------------------------
// tb_preg_freelist
//   Directed, table-driven bench for preg_freelist with NPREG=8. Each table
//   row drives alloc/free for one cycle and lists the outputs expected just
//   after that rising edge. Hand-written sequences cover double free with a
//   long sticky-error window and an asynchronous reset during random traffic.
// ----------------------------------------------------------------------------
module tb_preg_freelist;

    localparam int NP = 8;
    localparam int IW = 3;

    logic          clk;
    logic          rstn;
    logic          alloc_i;
    logic          alloc_ready_o;
    logic [IW-1:0] alloc_preg_o;
    logic          free_i;
    logic [IW-1:0] free_preg_i;
    logic [IW:0]   count_o;
    logic          err_o;

    int checks;
    int errors;

    preg_freelist #(.NPREG(NP), .IDW(IW)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .alloc_i       (alloc_i),
        .alloc_ready_o (alloc_ready_o),
        .alloc_preg_o  (alloc_preg_o),
        .free_i        (free_i),
        .free_preg_i   (free_preg_i),
        .count_o       (count_o),
        .err_o         (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic          alloc;
        logic          free;
        logic [IW-1:0] fpreg;
        logic          ready;
        logic [IW-1:0] preg;
        logic [IW:0]   cnt;
        logic          err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string n, input logic a, input logic f, input int fp,
                       input logic r, input int p, input int c, input logic e);
        vec_t v;
        v.name  = n;
        v.alloc = a;
        v.free  = f;
        v.fpreg = IW'(fp);
        v.ready = r;
        v.preg  = IW'(p);
        v.cnt   = (IW + 1)'(c);
        v.err   = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string n);
        check({n, "_ready"}, int'(alloc_ready_o), 1);
        check({n, "_preg"},  int'(alloc_preg_o),  0);
        check({n, "_count"}, int'(count_o),       NP);
        check({n, "_err"},   int'(err_o),         0);
    endtask

    task automatic do_reset();
        alloc_i     = 1'b0;
        free_i      = 1'b0;
        free_preg_i = '0;
        rstn        = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
    endtask

    // One cycle: drive inputs, take the edge, sample 1 time unit later.
    task automatic step(input logic a, input logic f, input int fp);
        alloc_i     = a;
        free_i      = f;
        free_preg_i = IW'(fp);
        @(posedge clk);
        #1;
        alloc_i = 1'b0;
        free_i  = 1'b0;
    endtask

    initial begin
        int q[$];
        int held[$];
        checks = 0;
        errors = 0;

        // Drain: grants 0..7 in order, then one cycle with no grant.
        for (int k = 0; k < NP; k++) begin
            add("drain", 1'b1, 1'b0, 0, (k < NP - 1), (k < NP - 1) ? k + 1 : 0, NP - 1 - k, 1'b0);
        end
        add("no_grant_empty",  1'b1, 1'b0, 0, 1'b0, 0, 0, 1'b0);
        // Refill while empty; alloc held high proves no same-cycle bypass.
        add("refill5_nobyp",   1'b1, 1'b1, 5, 1'b1, 5, 1, 1'b0);
        add("refill2",         1'b0, 1'b1, 2, 1'b1, 5, 2, 1'b0);
        add("grant5",          1'b1, 1'b0, 0, 1'b1, 2, 1, 1'b0);
        add("grant2",          1'b1, 1'b0, 0, 1'b0, 2, 0, 1'b0);
        // Build count=3 then grant + legal free of 6 together.
        add("free0",           1'b0, 1'b1, 0, 1'b1, 0, 1, 1'b0);
        add("free1",           1'b0, 1'b1, 1, 1'b1, 0, 2, 1'b0);
        add("free3",           1'b0, 1'b1, 3, 1'b1, 0, 3, 1'b0);
        add("simul_free6",     1'b1, 1'b1, 6, 1'b1, 1, 3, 1'b0);
        add("grant1",          1'b1, 1'b0, 0, 1'b1, 3, 2, 1'b0);
        add("grant3_see6",     1'b1, 1'b0, 0, 1'b1, 6, 1, 1'b0);
        add("grant6",          1'b1, 1'b0, 0, 1'b0, 6, 0, 1'b0);
        // Same-cycle alloc/free of the head id.
        add("free1_again",     1'b0, 1'b1, 1, 1'b1, 1, 1, 1'b0);
        add("same_id",         1'b1, 1'b1, 1, 1'b0, 7, 0, 1'b1);
        add("still_alloc",     1'b0, 1'b1, 1, 1'b1, 1, 1, 1'b1);

        rstn        = 1'b0;
        alloc_i     = 1'b0;
        free_i      = 1'b0;
        free_preg_i = '0;
        do_reset();
        check_reset_outputs("reset");

        foreach (tbl[i]) begin
            step(tbl[i].alloc, tbl[i].free, int'(tbl[i].fpreg));
            check({tbl[i].name, "_ready"}, int'(alloc_ready_o), int'(tbl[i].ready));
            check({tbl[i].name, "_preg"},  int'(alloc_preg_o),  int'(tbl[i].preg));
            check({tbl[i].name, "_count"}, int'(count_o),       int'(tbl[i].cnt));
            check({tbl[i].name, "_err"},   int'(err_o),         int'(tbl[i].err));
        end

        // Double free of id 1, then err must stay set for 100 cycles.
        do_reset();
        check_reset_outputs("reset2");
        check("df_grant0", int'(alloc_preg_o), 0);
        step(1'b1, 1'b0, 0);
        check("df_grant1", int'(alloc_preg_o), 1);
        step(1'b1, 1'b0, 0);
        check("df_count6", int'(count_o), 6);
        step(1'b0, 1'b1, 1);
        check("df_first_count", int'(count_o), 7);
        check("df_first_err",   int'(err_o),   0);
        step(1'b0, 1'b1, 1);
        check("df_second_count", int'(count_o), 7);
        check("df_second_err",   int'(err_o),   1);
        for (int c = 0; c < 100; c++) begin
            step(1'b0, 1'b0, 0);
            check("df_sticky_err", int'(err_o), 1);
        end

        // Random legal traffic against a FIFO model, then async reset.
        do_reset();
        for (int i = 0; i < NP; i++) q.push_back(i);
        for (int cyc = 0; cyc < 20; cyc++) begin
            logic a;
            logic f;
            int   fp;
            int   idx;
            a  = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            f  = (held.size() > 0) && ($urandom_range(0, 1) == 1);
            fp = 0;
            idx = 0;
            if (f) begin
                idx = $urandom_range(0, held.size() - 1);
                fp  = held[idx];
            end
            check("rnd_count", int'(count_o), q.size());
            if (q.size() > 0) check("rnd_preg", int'(alloc_preg_o), q[0]);
            step(a, f, fp);
            if (f) begin
                held.delete(idx);
            end
            if (a) begin
                held.push_back(q.pop_front());
            end
            if (f) begin
                q.push_back(fp);
            end
        end
        check("rnd_count_end", int'(count_o), q.size());
        check("rnd_err",       int'(err_o),   0);

        // Reset asserted mid-cycle with traffic in flight; outputs must
        // return to reset values without waiting for a clock edge.
        @(posedge clk);
        #2;
        alloc_i     = 1'b1;
        free_i      = 1'b1;
        free_preg_i = 3'd2;
        rstn        = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rstn    = 1'b1;
        alloc_i = 1'b0;
        free_i  = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_preg_freelist
